// File: rtl/warp_xrf_sb_pkg.sv
// Shared parameters and FSM encoding for the warp integer register file.
package warp_xrf_sb_pkg;

  localparam int unsigned XRF_XLEN_DEFAULT  = 64;
  localparam int unsigned XRF_NREGS_DEFAULT = 32;
  localparam int unsigned XRF_NRD_DEFAULT   = 4;
  localparam int unsigned XRF_NWR_DEFAULT   = 2;

  // Init sweep runs once after reset; READY is terminal until the next reset.
  typedef enum logic {
    XRF_ST_INIT  = 1'b0,
    XRF_ST_READY = 1'b1
  } xrf_state_e;

endpackage

// File: rtl/warp_xrf_sb_if.sv
// Issue/writeback bundle of the register file. master = issue side, slave = register file.
interface warp_xrf_sb_if
  import warp_xrf_sb_pkg::*;
#(
  parameter int unsigned XLEN  = XRF_XLEN_DEFAULT,
  parameter int unsigned NREGS = XRF_NREGS_DEFAULT,
  parameter int unsigned NRD   = XRF_NRD_DEFAULT,
  parameter int unsigned NWR   = XRF_NWR_DEFAULT
);
  localparam int unsigned AW = $clog2(NREGS);

  logic [NRD*AW-1:0]   i_rs_addr;
  logic [NRD*XLEN-1:0] o_rs_rdata;
  logic [NWR*AW-1:0]   i_rd_addr;
  logic [NWR*XLEN-1:0] i_rd_wdata;
  logic [NWR-1:0]      i_rd_wen;
  logic                i_rsv_en;
  logic [AW-1:0]       i_rsv_addr;
  logic [NREGS-1:0]    o_busy;
  logic                o_ready;

  modport master (
    output i_rs_addr, i_rd_addr, i_rd_wdata, i_rd_wen, i_rsv_en, i_rsv_addr,
    input  o_rs_rdata, o_busy, o_ready
  );

  modport slave (
    input  i_rs_addr, i_rd_addr, i_rd_wdata, i_rd_wen, i_rsv_en, i_rsv_addr,
    output o_rs_rdata, o_busy, o_ready
  );

endinterface

// File: rtl/warp_xrf_scoreboard.sv
// Per-register busy flops. A reserve beats a same-cycle clear; x0 is never busy.
module warp_xrf_scoreboard
  import warp_xrf_sb_pkg::*;
#(
  parameter int unsigned NREGS = XRF_NREGS_DEFAULT,
  parameter int unsigned NWR   = XRF_NWR_DEFAULT
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_en,
  input  logic                          i_rsv_en,
  input  logic [$clog2(NREGS)-1:0]      i_rsv_addr,
  input  logic [NWR*$clog2(NREGS)-1:0]  i_clr_addr,
  input  logic [NWR-1:0]                i_clr_en,
  output logic [NREGS-1:0]              o_busy
);
  localparam int unsigned AW = $clog2(NREGS);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Next busy vector: clears first, then the reserve overrides them.
  always_comb begin
    busy_d = busy_q;
    if (i_en) begin
      for (int unsigned k = 0; k < NWR; k++) begin
        if (i_clr_en[k]) busy_d[i_clr_addr[k*AW +: AW]] = 1'b0;
      end
      if (i_rsv_en && (i_rsv_addr != AW'(0))) busy_d[i_rsv_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Busy flop bank.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  assign o_busy = busy_q;

endmodule

// File: rtl/warp_xrf_sb.sv
// Parametrised integer register file with init sweep, registered reads and busy scoreboard.
// Optional feature: define WARP_XRF_BYPASS_EN to forward same-cycle write data to reads.
module warp_xrf_sb
  import warp_xrf_sb_pkg::*;
#(
  parameter int unsigned XLEN  = XRF_XLEN_DEFAULT,
  parameter int unsigned NREGS = XRF_NREGS_DEFAULT,
  parameter int unsigned NRD   = XRF_NRD_DEFAULT,
  parameter int unsigned NWR   = XRF_NWR_DEFAULT
) (
  input logic          i_clk,
  input logic          i_rst_n,
  warp_xrf_sb_if.slave xrf
);
  localparam int unsigned AW = $clog2(NREGS);

  xrf_state_e          state_q, state_d;
  logic [AW-1:0]       ptr_q, ptr_d;
  logic [XLEN-1:0]     mem [NREGS];
  logic [NRD*XLEN-1:0] rdata_q, rdata_d;
  logic                ready_c;

  assign ready_c = (state_q == XRF_ST_READY);

  // State and sweep pointer registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= XRF_ST_INIT;
      ptr_q   <= AW'(1);
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Sweep sequencing: walk x1..x(NREGS-1), then park in READY.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      XRF_ST_INIT: begin
        if (ptr_q == AW'(NREGS - 1)) state_d = XRF_ST_READY;
        else                         ptr_d   = ptr_q + AW'(1);
      end
      XRF_ST_READY: ;
      default: state_d = XRF_ST_INIT;
    endcase
  end

  // Storage: sweep zeroes in INIT; in READY later write ports override earlier ones.
  always_ff @(posedge i_clk) begin
    if (state_q == XRF_ST_INIT) begin
      mem[ptr_q] <= '0;
    end else begin
      for (int unsigned k = 0; k < NWR; k++) begin
        if (xrf.i_rd_wen[k] && (xrf.i_rd_addr[k*AW +: AW] != AW'(0)))
          mem[xrf.i_rd_addr[k*AW +: AW]] <= xrf.i_rd_wdata[k*XLEN +: XLEN];
      end
    end
  end

  // Read data selection; x0 and the whole INIT phase read as zero.
  always_comb begin
    rdata_d = '0;
    if (ready_c) begin
      for (int unsigned k = 0; k < NRD; k++) begin
        if (xrf.i_rs_addr[k*AW +: AW] != AW'(0)) begin
          rdata_d[k*XLEN +: XLEN] = mem[xrf.i_rs_addr[k*AW +: AW]];
`ifdef WARP_XRF_BYPASS_EN
          for (int unsigned w = 0; w < NWR; w++) begin
            if (xrf.i_rd_wen[w] && (xrf.i_rd_addr[w*AW +: AW] == xrf.i_rs_addr[k*AW +: AW]))
              rdata_d[k*XLEN +: XLEN] = xrf.i_rd_wdata[w*XLEN +: XLEN];
          end
`endif
        end
      end
    end
  end

  // Read data registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rdata_q <= '0;
    else          rdata_q <= rdata_d;
  end

  warp_xrf_scoreboard #(
    .NREGS (NREGS),
    .NWR   (NWR)
  ) u_scoreboard (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_en       (ready_c),
    .i_rsv_en   (xrf.i_rsv_en),
    .i_rsv_addr (xrf.i_rsv_addr),
    .i_clr_addr (xrf.i_rd_addr),
    .i_clr_en   (xrf.i_rd_wen),
    .o_busy     (xrf.o_busy)
  );

  assign xrf.o_rs_rdata = rdata_q;
  assign xrf.o_ready    = ready_c;

endmodule
